adder_result_checker: RTL and testbench
=======================================

ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the vector-count, index and tally fields.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  begins a checking run when sampled high in IDLE or DONE.
REQ-006 num_vec  input  CNT_W  number of vectors in the run, latched when start is accepted.
REQ-007 in_valid  input  1  the upstream adder presents a valid vector.
REQ-008 in_ready  output  1  the checker accepts a vector this cycle; a vector transfers when in_valid and in_ready are both high.
REQ-009 a, b  input  WIDTH each  operands that were applied to the adder.
REQ-010 cin  input  1  carry-in that was applied to the adder.
REQ-011 sum  input  WIDTH  sum produced by the adder under test.
REQ-012 cout  input  1  carry-out produced by the adder under test.
REQ-013 pass_cnt, fail_cnt  output  CNT_W each  tallies of matching and mismatching vectors.
REQ-014 first_fail_idx  output  CNT_W  zero-based index of the first mismatching vector in the run.
REQ-015 fail_seen  output  1  at least one mismatch has occurred in the current run.
REQ-016 mismatch  output  1  one-cycle pulse reporting that the most recently accepted vector mismatched.
REQ-017 done  output  1  high while the block is in DONE.

Function
REQ-018 The state machine SHALL have three states: IDLE, RUN and DONE; in_ready SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-019 In IDLE or DONE, start=1 SHALL clear pass_cnt, fail_cnt, first_fail_idx, fail_seen and the internal index, latch num_vec, and move to RUN; if num_vec=0, the block SHALL move to DONE instead.
REQ-020 In RUN, start SHALL be ignored.
REQ-021 On each transfer, expected = a + b + cin SHALL be computed at WIDTH+1 bits and compared with {cout, sum}; a match SHALL increment pass_cnt, and a mismatch SHALL increment fail_cnt.
REQ-022 Counter and flag updates SHALL occur on the clock edge that accepts the vector, so the results are visible in the following cycle (latency 1).
REQ-023 mismatch SHALL be high for exactly the one cycle after a failing transfer and low otherwise; back-to-back failures SHALL keep it high for consecutive cycles.
REQ-024 On the first mismatch of a run, first_fail_idx SHALL capture the index of that vector and fail_seen SHALL be set; later mismatches SHALL leave first_fail_idx unchanged.
REQ-025 The index SHALL increment on each transfer; when the transfer that brings the index to num_vec occurs, the state SHALL become DONE on that same edge.
REQ-026 in_valid=0 in RUN SHALL stall the run with no state change.
REQ-027 pass_cnt and fail_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 All outputs SHALL hold their values in DONE until the next accepted start.
REQ-029 Changes on num_vec after start is accepted SHALL have no effect on the current run.

Reset
REQ-030 When rst=1 at a rising edge, the state SHALL become IDLE regardless of the current state, including mid-run.
REQ-031 When rst=1 at a rising edge, pass_cnt, fail_cnt, first_fail_idx and the internal index SHALL be 0.
REQ-032 When rst=1 at a rising edge, fail_seen, mismatch, done and in_ready SHALL be 0.
REQ-033 rst SHALL take priority over start and over any transfer in the same cycle.

Verification
REQ-034 Pass run: start with num_vec=3, then transfer a=0000,b=0000,cin=0,sum=0000,cout=0; a=1000,b=0001,cin=0,sum=1001,cout=0; a=1111,b=0001,cin=0,sum=0000,cout=1 -> pass_cnt=3, fail_cnt=0, fail_seen=0, done=1.
REQ-035 Fail run: num_vec=2, with vector 0 as a=0100,b=0100,cin=1,sum=1000,cout=0 (wrong) and vector 1 as a=1000,b=1000,cin=1,sum=0001,cout=1 (correct) -> mismatch pulses once, first_fail_idx=0, pass_cnt=1, fail_cnt=1.
REQ-036 Stall: in_valid low for 5 cycles mid-run -> counters frozen, state stays RUN, in_ready=1.
REQ-037 Zero-length run: start with num_vec=0 -> done=1 the next cycle, all counts 0.
REQ-038 Mid-run reset: rst=1 after 1 of 3 vectors -> all outputs 0 and state IDLE the next cycle; a new start then runs cleanly.
REQ-039 Restart: start asserted in DONE -> counters cleared and the block returns to RUN; start asserted during RUN is ignored.

Source files
------------

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_result_checker
// Purpose  : Scoreboard for an adder under test. Each accepted vector's
//            {cout, sum} is compared against a + b + cin. The block tallies
//            matches and mismatches, records the index of the first mismatch,
//            and pulses mismatch for one cycle after each failing vector.
// Ports    : clk, rst              - clock and synchronous active-high reset
//            start, num_vec        - begin a run of num_vec vectors
//            in_valid / in_ready   - vector handshake (ready only in RUN)
//            a, b, cin, sum, cout  - operands and adder result under check
//            pass_cnt, fail_cnt    - saturating tallies
//            first_fail_idx        - index of the first mismatching vector
//            fail_seen, mismatch   - sticky / one-cycle failure indications
//            done                  - high while in DONE
// Revision : 1.0  initial release
// ============================================================================
module adder_result_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             fail_seen,
  output logic             mismatch,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] nvec_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] first_fail_idx_q;
  logic             fail_seen_q;
  logic             mismatch_q;

  logic [WIDTH:0]   w_expected;
  logic             w_fail;
  logic             w_xfer;

  // Reference sum carried at WIDTH+1 bits so the carry-out is compared too.
  assign w_expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign w_fail     = (w_expected != {cout, sum});
  assign w_xfer     = (state_q == RUN) && in_valid;
  assign idx_d      = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      nvec_q           <= '0;
      pass_cnt_q       <= '0;
      fail_cnt_q       <= '0;
      first_fail_idx_q <= '0;
      fail_seen_q      <= 1'b0;
      mismatch_q       <= 1'b0;
    end else begin
      // mismatch is a pulse: only a failing transfer raises it for one cycle.
      mismatch_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            idx_q            <= '0;
            nvec_q           <= num_vec;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            first_fail_idx_q <= '0;
            fail_seen_q      <= 1'b0;
            state_q          <= (num_vec == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_xfer) begin
            idx_q <= idx_d;
            if (w_fail) begin
              mismatch_q <= 1'b1;
              if (fail_cnt_q != C_CNT_MAX) fail_cnt_q <= fail_cnt_q + 1'b1;
              if (!fail_seen_q) begin
                fail_seen_q      <= 1'b1;
                first_fail_idx_q <= idx_q;
              end
            end else begin
              if (pass_cnt_q != C_CNT_MAX) pass_cnt_q <= pass_cnt_q + 1'b1;
            end
            // Leave RUN on the same edge that accepts the last vector.
            if (idx_d == nvec_q) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_fail_idx_q;
  assign fail_seen      = fail_seen_q;
  assign mismatch       = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_result_checker
// Purpose  : Self-checking bench for adder_result_checker using a table of
//            hand-computed vectors plus directed multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_result_checker;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, cout;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic             fail_seen, mismatch, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_vec       (num_vec),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .sum           (sum),
    .cout          (cout),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .first_fail_idx(first_fail_idx),
    .fail_seen     (fail_seen),
    .mismatch      (mismatch),
    .done          (done)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       exp_fail;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    num_vec = n;
    step();
    start   = 1'b0;
  endtask

  task automatic xfer(input logic [3:0] ia, input logic [3:0] ib, input logic icin,
                      input logic [3:0] isum, input logic icout);
    in_valid = 1'b1;
    a = ia; b = ib; cin = icin; sum = isum; cout = icout;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int p, input int f, input int ffi,
                            input logic fs, input logic mm, input logic dn, input logic rdy);
    check({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(p));
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(f));
    check({tag, ".first_fail_idx"}, 32'(first_fail_idx), 32'(ffi));
    check({tag, ".fail_seen"}, 32'(fail_seen), 32'(fs));
    check({tag, ".mismatch"}, 32'(mismatch), 32'(mm));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  initial begin
    int exp_p, exp_f, exp_ffi;
    logic exp_fs;

    // a, b, cin, sum, cout, fail  (expected results worked out by hand)
    tbl[0] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0}; // 7
    tbl[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0}; // 31
    tbl[2] = '{4'h5, 4'hA, 1'b1, 4'h0, 1'b0, 1'b1}; // 16, cout wrong
    tbl[3] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b0}; // 15
    tbl[4] = '{4'h7, 4'h8, 1'b1, 4'h1, 1'b1, 1'b1}; // 16, sum wrong
    tbl[5] = '{4'hC, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0}; // 16
    tbl[6] = '{4'h2, 4'h2, 1'b0, 4'h4, 1'b1, 1'b1}; // 4, cout wrong
    tbl[7] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0}; // 1

    rst = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
    step(); step();
    check_outs("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_outs("idle", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- Table-driven run ----------------
    do_start(8'd8);
    check_outs("tbl_start", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_p = 0; exp_f = 0; exp_ffi = 0; exp_fs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout);
      if (tbl[i].exp_fail) begin
        exp_f++;
        if (!exp_fs) begin exp_fs = 1'b1; exp_ffi = i; end
      end else begin
        exp_p++;
      end
      check_outs($sformatf("tbl%0d", i), exp_p, exp_f, exp_ffi, exp_fs,
                 tbl[i].exp_fail, (i == 7), (i != 7));
    end
    step(); step();
    check_outs("tbl_hold", 5, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0);

    // ---------------- Pass run ----------------
    do_start(8'd3);
    check_outs("pass_start", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    xfer(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    xfer(4'b1000, 4'b0001, 1'b0, 4'b1001, 1'b0);
    xfer(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    check_outs("pass_end", 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---------------- Fail run ----------------
    do_start(8'd2);
    xfer(4'b0100, 4'b0100, 1'b1, 4'b1000, 1'b0);
    check_outs("fail_v0", 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    xfer(4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b1);
    check_outs("fail_v1", 1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // ---------------- Back-to-back failures ----------------
    do_start(8'd2);
    xfer(4'h1, 4'h1, 1'b0, 4'h3, 1'b0);
    check_outs("b2b_v0", 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    xfer(4'h1, 4'h1, 1'b0, 4'h2, 1'b1);
    check_outs("b2b_v1", 0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_outs("b2b_after", 0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // ------- Stall, ignored start and num_vec change during RUN -------
    do_start(8'd3);
    xfer(4'h2, 4'h3, 1'b0, 4'h5, 1'b0);
    start = 1'b1; num_vec = 8'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_outs($sformatf("stall%0d", k), 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    start = 1'b0; num_vec = 8'd9;
    xfer(4'h6, 4'h1, 1'b1, 4'h8, 1'b0);
    check_outs("stall_v1", 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    xfer(4'h6, 4'h1, 1'b1, 4'h9, 1'b0);
    check_outs("stall_v2", 2, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0);

    // ---------------- Zero-length run (also clears prior counts) ----------------
    do_start(8'd0);
    check_outs("zero_len", 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---------------- Mid-run reset with competing start and transfer ----------------
    do_start(8'd3);
    xfer(4'h4, 4'h4, 1'b0, 4'h0, 1'b0);
    check_outs("mrst_v0", 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1; start = 1'b1; num_vec = 8'd1; in_valid = 1'b1;
    a = 4'h1; b = 4'h1; cin = 1'b0; sum = 4'h2; cout = 1'b0;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_outs("mrst", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("mrst_idle", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(8'd1);
    xfer(4'h9, 4'h9, 1'b0, 4'h2, 1'b1);
    check_outs("mrst_rerun", 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---------------- Longest run: 255 passing vectors ----------------
    do_start(8'd255);
    for (int k = 0; k < 255; k++) xfer(4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    check_outs("max_run", 255, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
